// File: rtl/bp_cce_pkg.sv
// Shared CCE definitions: coherence states, MSHR field selectors and the packed MSHR entry layout.
// Entry widths follow the default system configuration; the MSHR file checks its parameters against them.
package bp_cce_pkg;

    localparam int paddr_width_lp  = 40;
    localparam int lce_id_width_lp = 4;
    localparam int lce_assoc_lp    = 8;
    localparam int way_width_lp    = $clog2(lce_assoc_lp);
    localparam int num_flags_lp    = 16;
    localparam int gpr_width_lp    = 64;
    localparam int block_offset_lp = 6;

    typedef enum logic [2:0] {
        e_COH_I = 3'b000,
        e_COH_S = 3'b001,
        e_COH_E = 3'b010,
        e_COH_F = 3'b011,
        e_COH_M = 3'b110,
        e_COH_O = 3'b111
    } bp_coh_states_e;

    typedef enum logic [3:0] {
        e_mshr_lce_id      = 4'd0,
        e_mshr_paddr       = 4'd1,
        e_mshr_lru_way     = 4'd2,
        e_mshr_way         = 4'd3,
        e_mshr_owner_lce   = 4'd4,
        e_mshr_owner_way   = 4'd5,
        e_mshr_next_coh    = 4'd6,
        e_mshr_lru_coh     = 4'd7,
        e_mshr_owner_coh   = 4'd8,
        e_mshr_uc_size     = 4'd9,
        e_mshr_data_length = 4'd10,
        e_mshr_lru_paddr   = 4'd11
    } bp_cce_mshr_field_e;

    localparam int bp_cce_mshr_num_fields = 12;

    typedef struct packed {
        logic [lce_id_width_lp-1:0] lce_id;
        logic [paddr_width_lp-1:0]  paddr;
        logic [way_width_lp-1:0]    lru_way;
        logic [way_width_lp-1:0]    way;
        logic [lce_id_width_lp-1:0] owner_lce_id;
        logic [way_width_lp-1:0]    owner_way;
        logic [2:0]                 next_coh_state;
        logic [2:0]                 lru_coh_state;
        logic [2:0]                 owner_coh_state;
        logic [2:0]                 uc_req_size;
        logic [2:0]                 data_length;
        logic [paddr_width_lp-1:0]  lru_paddr;
        logic [num_flags_lp-1:0]    flags;
    } bp_cce_mshr_s;

endpackage

// File: rtl/bp_cce_mshr_entry.sv
// One MSHR slot: storage plus field/flag update. Clear beats allocation, which beats field writes;
// the parent only ever allocates into an invalid slot and only writes or clears a valid one.
module bp_cce_mshr_entry
    import bp_cce_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alloc,
    input  logic [lce_id_width_lp-1:0]        alloc_lce_id,
    input  logic [paddr_width_lp-1:0]         alloc_paddr,
    input  logic [2:0]                        alloc_coh,
    input  logic                              write,
    input  logic [bp_cce_mshr_num_fields-1:0] field_w_v,
    input  logic [gpr_width_lp-1:0]           field_data,
    input  logic [num_flags_lp-1:0]           flag_w_mask,
    input  logic [num_flags_lp-1:0]           flag_data,
    input  logic                              clear,
    output logic [$bits(bp_cce_mshr_s)-1:0]   entry,
    output logic                              valid
);

    bp_cce_mshr_s entry_r;
    bp_cce_mshr_s entry_n;
    bp_cce_mshr_s alloc_entry;
    logic         unused_field_data;

    assign unused_field_data = ^field_data[gpr_width_lp-1:paddr_width_lp];
    assign entry             = entry_r;

    always_comb begin
        alloc_entry                = '0;
        alloc_entry.lce_id         = alloc_lce_id;
        alloc_entry.paddr          = alloc_paddr;
        alloc_entry.next_coh_state = alloc_coh;

        // Each selected field takes the low bits of the shared write bus
        entry_n = entry_r;
        if (field_w_v[e_mshr_lce_id])      entry_n.lce_id          = field_data[lce_id_width_lp-1:0];
        if (field_w_v[e_mshr_paddr])       entry_n.paddr           = field_data[paddr_width_lp-1:0];
        if (field_w_v[e_mshr_lru_way])     entry_n.lru_way         = field_data[way_width_lp-1:0];
        if (field_w_v[e_mshr_way])         entry_n.way             = field_data[way_width_lp-1:0];
        if (field_w_v[e_mshr_owner_lce])   entry_n.owner_lce_id    = field_data[lce_id_width_lp-1:0];
        if (field_w_v[e_mshr_owner_way])   entry_n.owner_way       = field_data[way_width_lp-1:0];
        if (field_w_v[e_mshr_next_coh])    entry_n.next_coh_state  = field_data[2:0];
        if (field_w_v[e_mshr_lru_coh])     entry_n.lru_coh_state   = field_data[2:0];
        if (field_w_v[e_mshr_owner_coh])   entry_n.owner_coh_state = field_data[2:0];
        if (field_w_v[e_mshr_uc_size])     entry_n.uc_req_size     = field_data[2:0];
        if (field_w_v[e_mshr_data_length]) entry_n.data_length     = field_data[2:0];
        if (field_w_v[e_mshr_lru_paddr])   entry_n.lru_paddr       = field_data[paddr_width_lp-1:0];
        for (int i = 0; i < num_flags_lp; i++) begin
            if (flag_w_mask[i]) entry_n.flags[i] = flag_data[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_r <= '0;
            valid   <= 1'b0;
        end else if (clear) begin
            entry_r <= '0;
            valid   <= 1'b0;
        end else if (alloc) begin
            entry_r <= alloc_entry;
            valid   <= 1'b1;
        end else if (write) begin
            entry_r <= entry_n;
        end
    end

endmodule

// File: rtl/bp_cce_mshr_file.sv
// Multi-entry CCE MSHR file: allocation into the lowest free slot, block-address conflict lookup,
// per-entry field/flag writes and retirement, plus the default next-coherence-state register.
module bp_cce_mshr_file
    import bp_cce_pkg::*;
#(
    parameter int num_mshr_p     = 4,
    parameter int paddr_width_p  = 40,
    parameter int lce_id_width_p = 4,
    parameter int lce_assoc_p    = 8,
    parameter int num_flags_p    = 16,
    parameter int gpr_width_p    = 64,
    parameter int block_offset_p = 6
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                stall_i,
    input  logic                                alloc_v_i,
    input  logic [lce_id_width_p-1:0]           alloc_lce_id_i,
    input  logic [paddr_width_p-1:0]            alloc_paddr_i,
    output logic                                alloc_ready_o,
    output logic [$clog2(num_mshr_p)-1:0]       alloc_id_o,
    input  logic [$clog2(num_mshr_p)-1:0]       sel_id_i,
    input  logic [bp_cce_mshr_num_fields-1:0]   field_w_v_i,
    input  logic [gpr_width_p-1:0]              field_data_i,
    input  logic [num_flags_p-1:0]              flag_w_mask_i,
    input  logic [num_flags_p-1:0]              flag_data_i,
    input  logic                                clear_v_i,
    input  logic                                coh_state_w_v_i,
    input  logic [2:0]                          coh_state_i,
    input  logic [paddr_width_p-1:0]            lookup_paddr_i,
    output logic                                lookup_hit_o,
    output logic [$clog2(num_mshr_p)-1:0]       lookup_id_o,
    output logic [$bits(bp_cce_mshr_s)-1:0]     mshr_o,
    output logic [num_mshr_p-1:0]               valid_o,
    output logic [$clog2(num_mshr_p+1)-1:0]     count_o,
    output logic [2:0]                          coh_state_o
);

    localparam int id_width_lp    = $clog2(num_mshr_p);
    localparam int count_width_lp = $clog2(num_mshr_p + 1);
    localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(num_mshr_p);

    if (num_mshr_p < 2 || paddr_width_p != paddr_width_lp || lce_id_width_p != lce_id_width_lp
        || lce_assoc_p != lce_assoc_lp || num_flags_p != num_flags_lp || gpr_width_p != gpr_width_lp
        || block_offset_p != block_offset_lp) begin : g_param_check
        $error("bp_cce_mshr_file: parameters disagree with the bp_cce_pkg entry layout");
    end

    logic [$bits(bp_cce_mshr_s)-1:0] entry_bits [num_mshr_p];
    logic [paddr_width_p-1:0]        entry_paddr [num_mshr_p];
    logic [num_mshr_p-1:0]           sel_hit, lookup_match, alloc_match, write_en, clear_en;
    logic                            alloc_fire, clear_fire, unused_lookup_offset;

    assign unused_lookup_offset = ^lookup_paddr_i[block_offset_p-1:0];

    for (genvar i = 0; i < num_mshr_p; i++) begin : g_entry
        bp_cce_mshr_s entry;

        assign entry           = entry_bits[i];
        assign entry_paddr[i]  = entry.paddr;
        assign sel_hit[i]      = (sel_id_i == id_width_lp'(i));
        assign write_en[i]     = ~stall_i & sel_hit[i] & valid_o[i];
        assign clear_en[i]     = write_en[i] & clear_v_i;
        assign lookup_match[i] = valid_o[i] & (entry_paddr[i][paddr_width_p-1:block_offset_p]
                                               == lookup_paddr_i[paddr_width_p-1:block_offset_p]);
        assign alloc_match[i]  = valid_o[i] & (entry_paddr[i][paddr_width_p-1:block_offset_p]
                                               == alloc_paddr_i[paddr_width_p-1:block_offset_p]);

        bp_cce_mshr_entry u_entry (
            .clk          (clk_i),
            .reset        (reset_i),
            .alloc        (alloc_fire & (alloc_id_o == id_width_lp'(i))),
            .alloc_lce_id (alloc_lce_id_i),
            .alloc_paddr  (alloc_paddr_i),
            .alloc_coh    (coh_state_o),
            .write        (write_en[i]),
            .field_w_v    (field_w_v_i),
            .field_data   (field_data_i),
            .flag_w_mask  (flag_w_mask_i),
            .flag_data    (flag_data_i),
            .clear        (clear_en[i]),
            .entry        (entry_bits[i]),
            .valid        (valid_o[i])
        );
    end

    // Downward scans so the lowest index wins both the free-slot and the hit search
    always_comb begin
        alloc_id_o  = '0;
        lookup_id_o = '0;
        mshr_o      = '0;
        for (int i = num_mshr_p - 1; i >= 0; i--) begin
            if (!valid_o[i])     alloc_id_o  = id_width_lp'(i);
            if (lookup_match[i]) lookup_id_o = id_width_lp'(i);
            if (sel_hit[i])      mshr_o      = entry_bits[i];
        end
    end

    assign lookup_hit_o  = |lookup_match;
    assign alloc_ready_o = (count_o < full_count_lp) & ~(|alloc_match);
    assign alloc_fire    = alloc_v_i & alloc_ready_o;
    assign clear_fire    = |clear_en;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else if (alloc_fire & ~clear_fire) begin
            count_o <= count_o + count_width_lp'(1);
        end else if (clear_fire & ~alloc_fire) begin
            count_o <= count_o - count_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            coh_state_o <= e_COH_I;
        end else if (~stall_i & coh_state_w_v_i) begin
            coh_state_o <= coh_state_i;
        end
    end

    assert property (@(posedge clk_i) disable iff (reset_i)
                     count_o == count_width_lp'($countones(valid_o)));

endmodule

// File: tb/tb_bp_cce_mshr_file.sv
// Directed and randomized checks of the MSHR file against a slot-array reference model.
module tb_bp_cce_mshr_file;
    import bp_cce_pkg::*;

    localparam int numEntries = 4;

    logic         clk, reset, stall, allocV, clearV, cohWV;
    logic [3:0]   allocLceId;
    logic [39:0]  allocPaddr, lookupPaddr;
    logic [1:0]   selId;
    logic [11:0]  fieldWV;
    logic [63:0]  fieldData;
    logic [15:0]  flagMask, flagData;
    logic [2:0]   cohState;
    logic         allocReady, lookupHit;
    logic [1:0]   allocId, lookupId;
    logic [127:0] mshr;
    logic [3:0]   validVec;
    logic [2:0]   count, cohOut;

    bp_cce_mshr_s modelEntry [numEntries];
    logic         modelValid [numEntries];
    logic [2:0]   modelCoh;
    int           checks = 0;
    int           errors = 0;
    bp_cce_mshr_s view;

    bp_cce_mshr_file dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .stall_i         (stall),
        .alloc_v_i       (allocV),
        .alloc_lce_id_i  (allocLceId),
        .alloc_paddr_i   (allocPaddr),
        .alloc_ready_o   (allocReady),
        .alloc_id_o      (allocId),
        .sel_id_i        (selId),
        .field_w_v_i     (fieldWV),
        .field_data_i    (fieldData),
        .flag_w_mask_i   (flagMask),
        .flag_data_i     (flagData),
        .clear_v_i       (clearV),
        .coh_state_w_v_i (cohWV),
        .coh_state_i     (cohState),
        .lookup_paddr_i  (lookupPaddr),
        .lookup_hit_o    (lookupHit),
        .lookup_id_o     (lookupId),
        .mshr_o          (mshr),
        .valid_o         (validVec),
        .count_o         (count),
        .coh_state_o     (cohOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any disagreement
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        stall = 0; allocV = 0; clearV = 0; cohWV = 0;
        allocLceId = '0; allocPaddr = '0; lookupPaddr = '0; selId = '0;
        fieldWV = '0; fieldData = '0; flagMask = '0; flagData = '0; cohState = '0;
    endtask

    function automatic logic sameBlock(input logic [39:0] a, input logic [39:0] b);
        return (a >> 6) == (b >> 6);
    endfunction

    function automatic int modelCount();
        int n = 0;
        for (int i = 0; i < numEntries; i++) if (modelValid[i]) n++;
        return n;
    endfunction

    function automatic logic modelReady(input logic [39:0] addr);
        if (modelCount() >= numEntries) return 1'b0;
        for (int i = 0; i < numEntries; i++) if (modelValid[i] && sameBlock(modelEntry[i].paddr, addr)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int modelFree();
        for (int i = 0; i < numEntries; i++) if (!modelValid[i]) return i;
        return 0;
    endfunction

    function automatic bp_cce_mshr_s applyFields(input bp_cce_mshr_s e);
        bp_cce_mshr_s r = e;
        logic [63:0] d = fieldData;
        if (fieldWV[0])  r.lce_id          = d[3:0];
        if (fieldWV[1])  r.paddr           = d[39:0];
        if (fieldWV[2])  r.lru_way         = d[2:0];
        if (fieldWV[3])  r.way             = d[2:0];
        if (fieldWV[4])  r.owner_lce_id    = d[3:0];
        if (fieldWV[5])  r.owner_way       = d[2:0];
        if (fieldWV[6])  r.next_coh_state  = d[2:0];
        if (fieldWV[7])  r.lru_coh_state   = d[2:0];
        if (fieldWV[8])  r.owner_coh_state = d[2:0];
        if (fieldWV[9])  r.uc_req_size     = d[2:0];
        if (fieldWV[10]) r.data_length     = d[2:0];
        if (fieldWV[11]) r.lru_paddr       = d[39:0];
        r.flags = (r.flags & ~flagMask) | (flagData & flagMask);
        return r;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < numEntries; i++) begin
            modelEntry[i] = '0;
            modelValid[i] = 1'b0;
        end
        modelCoh = e_COH_I;
    endtask

    task automatic modelUpdate();
        int target = modelFree();
        logic fire = allocV && modelReady(allocPaddr);
        bp_cce_mshr_s e;
        if (!stall && modelValid[selId]) begin
            if (clearV) begin
                modelEntry[selId] = '0;
                modelValid[selId] = 1'b0;
            end else begin
                modelEntry[selId] = applyFields(modelEntry[selId]);
            end
        end
        if (fire) begin
            e = '0;
            e.lce_id = allocLceId;
            e.paddr = allocPaddr;
            e.next_coh_state = modelCoh;
            modelEntry[target] = e;
            modelValid[target] = 1'b1;
        end
        if (!stall && cohWV) modelCoh = cohState;
    endtask

    task automatic checkModel();
        logic [3:0] expValid;
        logic expHit = 1'b0;
        int expHitId = 0;
        for (int i = numEntries - 1; i >= 0; i--) begin
            expValid[i] = modelValid[i];
            if (modelValid[i] && sameBlock(modelEntry[i].paddr, lookupPaddr)) begin
                expHit = 1'b1;
                expHitId = i;
            end
        end
        checkOutput("valid", 128'(validVec), 128'(expValid));
        checkOutput("count", 128'(count), 128'(modelCount()));
        checkOutput("cohState", 128'(cohOut), 128'(modelCoh));
        checkOutput("allocReady", 128'(allocReady), 128'(modelReady(allocPaddr)));
        if (modelCount() < numEntries) checkOutput("allocId", 128'(allocId), 128'(modelFree()));
        checkOutput("lookupHit", 128'(lookupHit), 128'(expHit));
        checkOutput("lookupId", 128'(lookupId), 128'(expHitId));
        checkOutput("mshr", mshr, 128'(modelEntry[selId]));
    endtask

    // One clock: check outputs mid-cycle, advance the model at the edge, return just after it
    task automatic applyStimulus();
        @(negedge clk);
        checkModel();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    initial begin
        logic [2:0] cohVals [6];
        cohVals = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

        idleInputs();
        reset = 1'b1;
        modelReset();
        #3;
        checkOutput("resetValid", 128'(validVec), 128'(0));
        checkOutput("resetCount", 128'(count), 128'(0));
        checkOutput("resetCoh", 128'(cohOut), 128'(e_COH_I));
        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1;

        // Block conflict detection
        allocV = 1; allocLceId = 4'd1; allocPaddr = 40'h1000;
        #1 checkOutput("conflictAllocId0", 128'(allocId), 128'(0));
        applyStimulus();
        allocV = 0; lookupPaddr = 40'h103F;
        #1 checkOutput("probeHit", 128'(lookupHit), 128'(1));
        checkOutput("probeId", 128'(lookupId), 128'(0));
        allocV = 1; allocPaddr = 40'h1040;
        #1 checkOutput("adjBlockReady", 128'(allocReady), 128'(1));
        applyStimulus();
        checkOutput("adjBlockValid", 128'(validVec), 128'(4'b0011));
        allocPaddr = 40'h1008;
        #1 checkOutput("sameBlockReady", 128'(allocReady), 128'(0));
        applyStimulus();
        checkOutput("sameBlockCount", 128'(count), 128'(2));

        // Asynchronous reset mid-cycle discards everything
        idleInputs();
        #2 reset = 1'b1;
        modelReset();
        #1;
        checkOutput("midResetValid", 128'(validVec), 128'(0));
        checkOutput("midResetCount", 128'(count), 128'(0));
        checkOutput("midResetCoh", 128'(cohOut), 128'(e_COH_I));
        checkOutput("midResetMshr", mshr, 128'(0));
        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1;

        // Fill all slots
        for (int i = 0; i < numEntries; i++) begin
            allocV = 1; allocLceId = 4'(i + 2); allocPaddr = 40'h1000 * 40'(i + 1);
            #1 checkOutput("fillId", 128'(allocId), 128'(i));
            applyStimulus();
        end
        allocV = 0; allocPaddr = 40'h9000;
        #1 checkOutput("fullCount", 128'(count), 128'(4));
        checkOutput("fullReady", 128'(allocReady), 128'(0));

        // Stall blocks field write and clear; releasing it lets the clear win
        stall = 1; selId = 2'd1; fieldWV = 12'h002; fieldData = 64'hABCDE00; clearV = 1;
        applyStimulus();
        view = mshr;
        checkOutput("stallPaddr", 128'(view.paddr), 128'(40'h2000));
        checkOutput("stallValid", 128'(validVec), 128'(4'b1111));
        stall = 0;
        applyStimulus();
        checkOutput("clearWinsValid", 128'(validVec), 128'(4'b1101));
        checkOutput("clearWinsMshr", mshr, 128'(0));

        idleInputs();
        allocV = 1; allocPaddr = 40'h5000;
        #1 checkOutput("refillId", 128'(allocId), 128'(1));
        applyStimulus();

        // Clear while full: the slot is not reusable in the same cycle
        idleInputs();
        allocV = 1; allocPaddr = 40'h6000; selId = 2'd2; clearV = 1;
        #1 checkOutput("clearFullReady", 128'(allocReady), 128'(0));
        applyStimulus();
        checkOutput("clearFullValid", 128'(validVec), 128'(4'b1011));
        idleInputs();
        allocV = 1; allocPaddr = 40'h6000;
        #1 checkOutput("reuseId", 128'(allocId), 128'(2));
        applyStimulus();
        checkOutput("reuseCount", 128'(count), 128'(4));

        // Default coherence state captured by a new allocation, then a masked flag write
        idleInputs();
        selId = 2'd3; clearV = 1;
        applyStimulus();
        idleInputs();
        cohWV = 1; cohState = e_COH_S;
        applyStimulus();
        checkOutput("cohWrite", 128'(cohOut), 128'(e_COH_S));
        idleInputs();
        allocV = 1; allocPaddr = 40'h7000; allocLceId = 4'd9;
        #1 checkOutput("defaultAllocId", 128'(allocId), 128'(3));
        applyStimulus();
        idleInputs();
        selId = 2'd3; flagMask = 16'h0005; flagData = 16'hFFFF;
        applyStimulus();
        view = mshr;
        checkOutput("newNextCoh", 128'(view.next_coh_state), 128'(e_COH_S));
        checkOutput("maskedFlags", 128'(view.flags), 128'(16'h0005));
        checkOutput("newLceId", 128'(view.lce_id), 128'(4'd9));

        // Alloc and clear of different slots in the same cycle
        idleInputs();
        selId = 2'd0; clearV = 1;
        applyStimulus();
        idleInputs();
        allocV = 1; allocPaddr = 40'h8000; selId = 2'd1; clearV = 1;
        applyStimulus();
        checkOutput("swapValid", 128'(validVec), 128'(4'b1101));
        checkOutput("swapCount", 128'(count), 128'(3));

        // Randomized traffic over a small pool of blocks to force conflicts
        for (int n = 0; n < 400; n++) begin
            stall       = ($urandom_range(0, 3) == 0);
            allocV      = $urandom_range(0, 1) == 1;
            allocLceId  = 4'($urandom);
            allocPaddr  = 40'h1000 + 40'($urandom_range(0, 7)) * 40'h40 + 40'($urandom_range(0, 63));
            lookupPaddr = 40'h1000 + 40'($urandom_range(0, 7)) * 40'h40 + 40'($urandom_range(0, 63));
            selId       = 2'($urandom);
            fieldWV     = 12'($urandom & $urandom);
            fieldData   = {$urandom, $urandom};
            flagMask    = 16'($urandom);
            flagData    = 16'($urandom);
            clearV      = ($urandom_range(0, 4) == 0);
            cohWV       = ($urandom_range(0, 7) == 0);
            cohState    = cohVals[$urandom_range(0, 5)];
            applyStimulus();
        end

        idleInputs();
        applyStimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
